// File: rtl/fifo_pkg.sv
// Shared constants for the PCM audio-path FIFOs: default geometry and read-mode selectors.
package fifo_pkg;

  localparam int unsigned PCM_DAT_WIDTH = 16;
  localparam int unsigned PCM_ADR_WIDTH = 12;

  localparam int unsigned RD_REG  = 0;
  localparam int unsigned RD_FWFT = 1;

endpackage

// File: rtl/fifo_mem.sv
// Dual-port FIFO storage: synchronous write, read port registered or combinational by FWFT.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DAT_WIDTH = PCM_DAT_WIDTH,
  parameter int unsigned ADR_WIDTH = PCM_ADR_WIDTH,
  parameter int unsigned FWFT      = RD_REG
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADR_WIDTH-1:0] wr_addr,
  input  logic [DAT_WIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADR_WIDTH-1:0] rd_addr,
  output logic [DAT_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADR_WIDTH;

  logic [DAT_WIDTH-1:0] mem [DEPTH];

  // Storage carries no reset so it can map onto block or distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  if (FWFT == RD_FWFT) begin : g_fwft
    assign rd_data = mem[rd_addr];
  end else begin : g_reg
    logic [DAT_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_data_q <= '0;
      end else if (rd_en) begin
        rd_data_q <= mem[rd_addr];
      end
    end

    assign rd_data = rd_data_q;
  end

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock circular FIFO with fill level, threshold flags, sticky error flags and flush.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DAT_WIDTH  = PCM_DAT_WIDTH,
  parameter int unsigned ADR_WIDTH  = PCM_ADR_WIDTH,
  parameter int unsigned AFULL_LVL  = 3840,
  parameter int unsigned AEMPTY_LVL = 256,
  parameter int unsigned FWFT       = RD_REG
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 wr,
  input  logic [DAT_WIDTH-1:0] data_in,
  input  logic                 rd,
  output logic [DAT_WIDTH-1:0] data_out,
  output logic                 rd_valid,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [ADR_WIDTH:0]   level,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned DEPTH = 2 ** ADR_WIDTH;
  localparam int unsigned LVL_W = ADR_WIDTH + 1;

  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AFULL_L  = LVL_W'(AFULL_LVL);
  localparam logic [LVL_W-1:0] AEMPTY_L = LVL_W'(AEMPTY_LVL);

  logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             aempty_q, aempty_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_acc, rd_acc;
  logic             mem_wr_en, mem_rd_en;

  always_comb begin
    wr_acc    = wr & ~full_q;
    rd_acc    = rd & ~empty_q;
    mem_wr_en = wr_acc & ~clr;
    mem_rd_en = rd_acc & ~clr;

    wr_ptr_d   = wr_ptr_q + LVL_W'(wr_acc);
    rd_ptr_d   = rd_ptr_q + LVL_W'(rd_acc);
    level_d    = level_q + LVL_W'(wr_acc) - LVL_W'(rd_acc);
    ovf_d      = ovf_q | (wr & full_q);
    udf_d      = udf_q | (rd & empty_q);
    rd_valid_d = (FWFT == RD_REG) && rd_acc;

    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
      rd_valid_d = 1'b0;
    end

    // Flags come from the next level so they line up with level itself.
    full_d   = (level_d == DEPTH_L);
    empty_d  = (level_d == '0);
    afull_d  = (level_d >= AFULL_L);
    aempty_d = (level_d <= AEMPTY_L);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      aempty_q   <= 1'b1;
      afull_q    <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      aempty_q   <= aempty_d;
      afull_q    <= afull_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_mem #(
    .DAT_WIDTH(DAT_WIDTH),
    .ADR_WIDTH(ADR_WIDTH),
    .FWFT     (FWFT)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (mem_wr_en),
    .wr_addr(wr_ptr_q[ADR_WIDTH-1:0]),
    .wr_data(data_in),
    .rd_en  (mem_rd_en),
    .rd_addr(rd_ptr_q[ADR_WIDTH-1:0]),
    .rd_data(data_out)
  );

  assign rd_valid     = (FWFT == RD_FWFT) ? ~empty_q : rd_valid_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = aempty_q;
  assign almost_full  = afull_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags: registered-read and FWFT instances share one stimulus stream.
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic       wr;
  logic       rd;
  logic [7:0] data_in;

  logic [7:0] data_out, data_out_f;
  logic       rd_valid, rd_valid_f;
  logic       empty, empty_f, full, full_f;
  logic       aempty, aempty_f, afull, afull_f;
  logic [3:0] level, level_f;
  logic       ovf, ovf_f, udf, udf_f;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic       exp_rv = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_flags #(
    .DAT_WIDTH(8), .ADR_WIDTH(3), .AFULL_LVL(6), .AEMPTY_LVL(1), .FWFT(0)
  ) dut (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(data_out), .rd_valid(rd_valid), .empty(empty), .full(full),
    .almost_empty(aempty), .almost_full(afull), .level(level),
    .overflow(ovf), .underflow(udf)
  );

  fifo_sync_flags #(
    .DAT_WIDTH(8), .ADR_WIDTH(3), .AFULL_LVL(6), .AEMPTY_LVL(1), .FWFT(1)
  ) dut_f (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(data_out_f), .rd_valid(rd_valid_f), .empty(empty_f), .full(full_f),
    .almost_empty(aempty_f), .almost_full(afull_f), .level(level_f),
    .overflow(ovf_f), .underflow(udf_f)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; rv/ed give the read response expected after this edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                     input logic rv, input logic [7:0] ed);
    wr = w; data_in = d; rd = r;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
    exp_rv = rv;
    if (rv) exp_q.push_back(ed);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " level"}, 32'(level), 0);
    check({tag, " empty"}, 32'(empty), 1);
    check({tag, " almost_empty"}, 32'(aempty), 1);
    check({tag, " full"}, 32'(full), 0);
    check({tag, " almost_full"}, 32'(afull), 0);
    check({tag, " overflow"}, 32'(ovf), 0);
    check({tag, " underflow"}, 32'(udf), 0);
    check({tag, " rd_valid"}, 32'(rd_valid), 0);
    check({tag, " data_out"}, 32'(data_out), 0);
    check({tag, " fwft rd_valid"}, 32'(rd_valid_f), 0);
  endtask

  // Scoreboard monitor: rd_valid timing and popped data against queued expectations.
  always @(negedge clk) begin
    check("rd_valid", 32'(rd_valid), 32'(exp_rv));
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL data_out: got %0h with no word expected at %0t", data_out, $time);
      end else begin
        check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    clr = 1'b0; wr = 1'b0; rd = 1'b0; data_in = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;

    // 1. Fill from reset
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
      check("fill level", 32'(level), 32'(i));
      check("fill full", 32'(full), 32'(i == 8));
      check("fill almost_full", 32'(afull), 32'(i >= 6));
      check("fill almost_empty", 32'(aempty), 32'(i <= 1));
      check("fill empty", 32'(empty), 0);
    end

    // 2. Overflow, then drain
    cyc(1'b1, 8'h09, 1'b0, 1'b0, 8'h00);
    check("ovf level", 32'(level), 8);
    check("ovf flag", 32'(ovf), 1);
    check("ovf full", 32'(full), 1);
    for (int i = 1; i <= 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'(i));
    check("drain level", 32'(level), 0);
    check("drain empty", 32'(empty), 1);
    check("drain ovf sticky", 32'(ovf), 1);

    // 3. Wrap and simultaneous access
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 8'h00);
    check("wrap push level", 32'(level), 5);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h10 + i));
    check("wrap pop level", 32'(level), 0);
    cyc(1'b1, 8'hA0, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, 8'(8'hA0 + k), 1'b1, 1'b1, 8'(8'hA0 + k - 1));
      check("simul level", 32'(level), 1);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'hA5);
    check("simul final level", 32'(level), 0);

    // 4. Underflow, then flush
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check("udf flag", 32'(udf), 1);
    check("udf level", 32'(level), 0);
    clr = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    clr = 1'b0;
    check("clr underflow", 32'(udf), 0);
    check("clr overflow", 32'(ovf), 0);
    check("clr empty", 32'(empty), 1);
    check("clr almost_empty", 32'(aempty), 1);

    // 5. FWFT
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00);
    check("fwft data_out", 32'(data_out_f), 32'h5A);
    check("fwft empty", 32'(empty_f), 0);
    check("fwft rd_valid", 32'(rd_valid_f), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h5A);
    check("fwft pop empty", 32'(empty_f), 1);
    check("fwft pop rd_valid", 32'(rd_valid_f), 0);

    // 6. Asynchronous reset mid-stream with a read in flight
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h11);
    #1;
    reset = 1'b0;
    exp_rv = 1'b0;
    exp_q.delete();
    #1;
    check_reset_vals("async reset");
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
    check("post reset level", 32'(level), 1);
    check("post reset fwft data", 32'(data_out_f), 32'h33);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h33);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
